id_operand_sb: RTL and testbench

Parametrised operand-resolution and scoreboard unit for the decode stage. Selects each source operand from the register file, an immediate, or one of NUM_FWD forwarding buses. Tracks in-flight long-latency writes (loads, multi-cycle mul/div) in a per-register pending counter and raises a stall request on RAW hazards that forwarding cannot resolve. Sits between the decoder and the id/ex pipeline register and drives `stall_req` into the pipeline control block.

---
 rtl/id_operand_sb_if.sv | 46 ++++
 rtl/id_operand_sb.sv | 139 +++++++++++++
 tb/tb_id_operand_sb.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/id_operand_sb_if.sv
// Decoder <-> operand/scoreboard bundle: read ports, forwarding buses, issue and
// completion strobes in one direction, resolved operands and stall status back.
interface id_operand_sb_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 2
);
    logic                        rd1_en;
    logic                        rd2_en;
    logic [ADDR_W-1:0]           rd1_addr;
    logic [ADDR_W-1:0]           rd2_addr;
    logic [DATA_W-1:0]           rd1_data;
    logic [DATA_W-1:0]           rd2_data;
    logic [DATA_W-1:0]           imm;
    logic [NUM_FWD-1:0]          fwd_wreg;
    logic [NUM_FWD-1:0]          fwd_ready;
    logic [NUM_FWD*ADDR_W-1:0]   fwd_wd;
    logic [NUM_FWD*DATA_W-1:0]   fwd_wdata;
    logic                        issue_valid;
    logic                        issue_long;
    logic [ADDR_W-1:0]           issue_wd;
    logic                        cmpl_valid;
    logic [ADDR_W-1:0]           cmpl_wd;
    logic [DATA_W-1:0]           cmpl_wdata;
    logic [DATA_W-1:0]           reg1_o;
    logic [DATA_W-1:0]           reg2_o;
    logic                        stall_req;
    logic                        sb_err;
    logic                        pend_any;

    modport master (
        output rd1_en, rd2_en, rd1_addr, rd2_addr, rd1_data, rd2_data, imm,
               fwd_wreg, fwd_ready, fwd_wd, fwd_wdata,
               issue_valid, issue_long, issue_wd,
               cmpl_valid, cmpl_wd, cmpl_wdata,
        input  reg1_o, reg2_o, stall_req, sb_err, pend_any
    );

    modport slave (
        input  rd1_en, rd2_en, rd1_addr, rd2_addr, rd1_data, rd2_data, imm,
               fwd_wreg, fwd_ready, fwd_wd, fwd_wdata,
               issue_valid, issue_long, issue_wd,
               cmpl_valid, cmpl_wd, cmpl_wdata,
        output reg1_o, reg2_o, stall_req, sb_err, pend_any
    );
endinterface

// File: rtl/id_operand_sb.sv
// Decode-stage operand resolution (regfile / immediate / forwarding / completion)
// with a per-register pending-write scoreboard that raises stall_req on RAW hazards.
module id_operand_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    id_operand_sb_if.slave  sb
);
    localparam int               NUM_REGS = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0]  pend_q [NUM_REGS];
    logic [CNT_W-1:0]  pend_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_nz;
    logic              sb_err_q;
    logic              pend_any_q;

    logic              port_en    [2];
    logic [ADDR_W-1:0] port_addr  [2];
    logic [DATA_W-1:0] port_rdata [2];
    logic [DATA_W-1:0] port_val   [2];
    logic [1:0]        port_haz;

    logic ovf_haz, stall, accept, inc, dec, underflow;

    assign port_en[0]    = sb.rd1_en;
    assign port_en[1]    = sb.rd2_en;
    assign port_addr[0]  = sb.rd1_addr;
    assign port_addr[1]  = sb.rd2_addr;
    assign port_rdata[0] = sb.rd1_data;
    assign port_rdata[1] = sb.rd2_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic              fwd_hit, fwd_rdy, cmpl_hit, haz;
            logic [DATA_W-1:0] fwd_val, val;

            // Scan oldest to youngest so the lowest-index match wins.
            always_comb begin
                fwd_hit = 1'b0;
                fwd_rdy = 1'b0;
                fwd_val = '0;
                for (int i = NUM_FWD-1; i >= 0; i--) begin
                    if (sb.fwd_wreg[i] && sb.fwd_wd[i*ADDR_W +: ADDR_W] == port_addr[gi]) begin
                        fwd_hit = 1'b1;
                        fwd_rdy = sb.fwd_ready[i];
                        fwd_val = sb.fwd_wdata[i*DATA_W +: DATA_W];
                    end
                end
            end

            assign cmpl_hit = sb.cmpl_valid && (sb.cmpl_wd == port_addr[gi]);

            always_comb begin
                val = port_rdata[gi];
                haz = 1'b0;
                if (rst) begin
                    val = '0;
                end else if (!port_en[gi]) begin
                    val = sb.imm;
                end else if (port_addr[gi] == '0) begin
                    val = '0;
                end else if (fwd_hit) begin
                    val = fwd_val;
                    haz = ~fwd_rdy;
                end else if (cmpl_hit) begin
                    val = sb.cmpl_wdata;
                end else begin
                    haz = (pend_q[port_addr[gi]] != '0);
                end
            end

            assign port_val[gi] = val;
            assign port_haz[gi] = haz;
        end
    endgenerate

    assign ovf_haz   = sb.issue_valid && sb.issue_long && (sb.issue_wd != '0) &&
                       (pend_q[sb.issue_wd] == CNT_MAX);
    assign stall     = !rst && sb.issue_valid && ((|port_haz) || ovf_haz);
    assign accept    = sb.issue_valid && !stall;
    assign inc       = accept && sb.issue_long && (sb.issue_wd != '0);
    assign dec       = sb.cmpl_valid && (sb.cmpl_wd != '0);
    // A simultaneous issue to the same register cancels the decrement, so no underflow.
    assign underflow = dec && !(inc && sb.issue_wd == sb.cmpl_wd) && (pend_q[sb.cmpl_wd] == '0);

    assign pend_q[0]  = '0;
    assign pend_d[0]  = '0;
    assign pend_nz[0] = 1'b0;

    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic             inc_r, dec_r;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            assign inc_r = inc && (sb.issue_wd == ADDR_W'(gi));
            assign dec_r = dec && (sb.cmpl_wd == ADDR_W'(gi));

            always_comb begin
                cnt_d = cnt_q;
                if (inc_r && !dec_r) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (dec_r && !inc_r && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end

            assign pend_q[gi]  = cnt_q;
            assign pend_d[gi]  = cnt_d;
            assign pend_nz[gi] = (cnt_d != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err_q   <= 1'b0;
            pend_any_q <= 1'b0;
        end else begin
            sb_err_q   <= sb_err_q | underflow;
            pend_any_q <= |pend_nz;
        end
    end

    assign sb.reg1_o    = port_val[0];
    assign sb.reg2_o    = port_val[1];
    assign sb.stall_req = stall;
    assign sb.sb_err    = sb_err_q;
    assign sb.pend_any  = pend_any_q;
endmodule

// File: tb/tb_id_operand_sb.sv
// Directed bench for id_operand_sb: stimulus pushes expected values per cycle,
// a negedge monitor pops and compares them against the live outputs.
module tb_id_operand_sb;
    localparam int DATA_W = 32, ADDR_W = 5, NUM_FWD = 2, CNT_W = 2;
    localparam int S_R1 = 0, S_R2 = 1, S_ST = 2, S_PA = 3, S_ERR = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        string       name;
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_mon;
    logic [31:0] act_mon;

    id_operand_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) bus ();

    id_operand_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e_mon = exp_q.pop_front();
            case (e_mon.sel)
                S_R1:    act_mon = bus.reg1_o;
                S_R2:    act_mon = bus.reg2_o;
                S_ST:    act_mon = {31'b0, bus.stall_req};
                S_PA:    act_mon = {31'b0, bus.pend_any};
                default: act_mon = {31'b0, bus.sb_err};
            endcase
            n_cmp++;
            if (act_mon !== e_mon.val) begin
                n_bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e_mon.name, act_mon, e_mon.val, cyc);
            end else begin
                $display("ok   %s: 0x%0h (cycle %0d)", e_mon.name, act_mon, cyc);
            end
        end
    end

    task automatic chk(input int sel, input logic [31:0] v, input string nm);
        exp_q.push_back('{nm, cyc, sel, v});
    endtask

    task automatic idle();
        bus.rd1_en = 0;  bus.rd2_en = 0;
        bus.rd1_addr = '0; bus.rd2_addr = '0;
        bus.rd1_data = '0; bus.rd2_data = '0;
        bus.imm = '0;
        bus.fwd_wreg = '0; bus.fwd_ready = '0; bus.fwd_wd = '0; bus.fwd_wdata = '0;
        bus.issue_valid = 0; bus.issue_long = 0; bus.issue_wd = '0;
        bus.cmpl_valid = 0; bus.cmpl_wd = '0; bus.cmpl_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_fwd(input int i, input logic rdy, input logic [ADDR_W-1:0] wd,
                           input logic [DATA_W-1:0] data);
        bus.fwd_wreg[i]                   = 1'b1;
        bus.fwd_ready[i]                  = rdy;
        bus.fwd_wd[i*ADDR_W +: ADDR_W]    = wd;
        bus.fwd_wdata[i*DATA_W +: DATA_W] = data;
    endtask

    task automatic read1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.rd1_en = 1; bus.rd1_addr = a; bus.rd1_data = d;
    endtask

    task automatic issue(input logic lng, input logic [ADDR_W-1:0] wd);
        bus.issue_valid = 1; bus.issue_long = lng; bus.issue_wd = wd;
    endtask

    task automatic cmpl(input logic [ADDR_W-1:0] wd, input logic [DATA_W-1:0] d);
        bus.cmpl_valid = 1; bus.cmpl_wd = wd; bus.cmpl_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        // Reset: outputs forced to zero even with hazardous inputs present
        for (int k = 0; k < 2; k++) begin
            step();
            read1(5'd3, 32'h99); bus.imm = 32'h5A; issue(1'b0, 5'd0); set_fwd(0, 1'b0, 5'd3, 32'hDEAD);
            chk(S_R1, 32'h0, "rst_reg1"); chk(S_R2, 32'h0, "rst_reg2"); chk(S_ST, 0, "rst_stall");
            if (k == 1) begin chk(S_PA, 0, "rst_pend_any"); chk(S_ERR, 0, "rst_sb_err"); end
        end
        step(); rst = 0;
        chk(S_ST, 0, "idle_stall"); chk(S_PA, 0, "idle_pend_any"); chk(S_ERR, 0, "idle_sb_err");

        // Forwarding priority
        step(); read1(5'd3, 32'h1234); bus.imm = 32'h5A5A; issue(1'b0, 5'd0);
        set_fwd(0, 1'b1, 5'd3, 32'hAAAA); set_fwd(1, 1'b1, 5'd3, 32'hBBBB);
        chk(S_R1, 32'hAAAA, "fwd0_wins"); chk(S_R2, 32'h5A5A, "imm_port2"); chk(S_ST, 0, "fwd0_nostall");
        step(); read1(5'd3, 32'h1234); issue(1'b0, 5'd0); set_fwd(1, 1'b1, 5'd3, 32'hBBBB);
        chk(S_R1, 32'hBBBB, "fwd1_only"); chk(S_ST, 0, "fwd1_nostall");
        step(); read1(5'd3, 32'h1234); issue(1'b0, 5'd0);
        chk(S_R1, 32'h1234, "regfile_data");

        // Load-use hazard on forwarding source
        step(); bus.rd2_en = 1; bus.rd2_addr = 5'd5; issue(1'b0, 5'd0); set_fwd(0, 1'b0, 5'd5, 32'hDEAD);
        chk(S_ST, 1, "load_use_stall");
        step(); bus.rd2_en = 1; bus.rd2_addr = 5'd5; issue(1'b0, 5'd0); set_fwd(1, 1'b1, 5'd5, 32'h77);
        chk(S_R2, 32'h77, "fwd1_resolves"); chk(S_ST, 0, "fwd1_resolves_stall");
        step(); bus.rd2_en = 1; bus.rd2_addr = 5'd5; issue(1'b0, 5'd0);
        set_fwd(0, 1'b0, 5'd5, 32'h0); set_fwd(1, 1'b1, 5'd5, 32'h77);
        chk(S_ST, 1, "older_match_ignored");
        step(); bus.rd2_en = 1; bus.rd2_addr = 5'd5; set_fwd(0, 1'b0, 5'd5, 32'h0);
        chk(S_ST, 0, "no_issue_no_stall");

        // Long-latency write to r7 and its completion
        step(); issue(1'b1, 5'd7);
        chk(S_ST, 0, "long_r7_accept");
        step(); issue(1'b0, 5'd0); read1(5'd7, 32'h0);
        chk(S_ST, 1, "r7_pending_stall"); chk(S_PA, 1, "r7_pend_any");
        step(); issue(1'b0, 5'd0); read1(5'd7, 32'h0);
        chk(S_ST, 1, "r7_stall_holds");
        step(); issue(1'b0, 5'd0); read1(5'd7, 32'h0); cmpl(5'd7, 32'h55);
        chk(S_R1, 32'h55, "cmpl_forward"); chk(S_ST, 0, "cmpl_unstall");
        step(); issue(1'b0, 5'd0); read1(5'd7, 32'h55);
        chk(S_ST, 0, "r7_cleared_stall"); chk(S_PA, 0, "r7_pend_any_clr"); chk(S_R1, 32'h55, "r7_regfile");

        // Counter saturation on r9
        for (int k = 0; k < 3; k++) begin
            step(); issue(1'b1, 5'd9);
            chk(S_ST, 0, $sformatf("r9_issue%0d", k));
        end
        step(); issue(1'b1, 5'd9); cmpl(5'd9, 32'h9);
        chk(S_ST, 1, "r9_overflow_stall"); chk(S_PA, 1, "r9_pend_any");
        step(); issue(1'b1, 5'd9);
        chk(S_ST, 0, "r9_fourth_accept");
        step(); issue(1'b1, 5'd9);
        chk(S_ST, 1, "r9_back_at_max");
        step(); cmpl(5'd9, 32'h9);
        step(); cmpl(5'd9, 32'h9);
        step(); cmpl(5'd9, 32'h9);
        chk(S_PA, 1, "r9_one_left");
        step();
        chk(S_PA, 0, "r9_drained"); chk(S_ERR, 0, "r9_no_err");

        // Same-cycle issue and completion to r11 cancel out
        step(); issue(1'b1, 5'd11);
        step(); issue(1'b1, 5'd11); cmpl(5'd11, 32'h11);
        chk(S_ST, 0, "r11_inc_dec");
        step(); issue(1'b0, 5'd0); read1(5'd11, 32'h0);
        chk(S_ST, 1, "r11_still_pending"); chk(S_PA, 1, "r11_pend_any");
        step(); cmpl(5'd11, 32'h11);
        step();
        chk(S_PA, 0, "r11_drained"); chk(S_ERR, 0, "r11_no_err");

        // Underflow error, r0 reads, reset clearing
        step(); cmpl(5'd4, 32'h44);
        step(); read1(5'd0, 32'h0); issue(1'b0, 5'd0); set_fwd(0, 1'b0, 5'd0, 32'hFFFF);
        chk(S_ERR, 1, "underflow_err"); chk(S_R1, 32'h0, "r0_reads_zero"); chk(S_ST, 0, "r0_no_stall");
        step(); issue(1'b1, 5'd12);
        chk(S_ERR, 1, "err_sticky");
        step(); rst = 1;
        step(); rst = 0; cmpl(5'd12, 32'h12);
        chk(S_ERR, 0, "err_cleared"); chk(S_PA, 0, "reset_discards");
        step();
        chk(S_ERR, 1, "post_reset_underflow");

        step();
        step();
        if (exp_q.size() != 0) begin
            $display("FAIL pending_checks: got %0d unchecked expected 0", exp_q.size());
            n_bad += exp_q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
